// File: rtl/sample_buffer.sv
// Multi-channel sample store: a write pass captures and echoes a run of CH-channel
// samples, and any number of read passes replay that run in order as a valid/last stream.
module sample_buffer #(
  parameter int CH    = 4,
  parameter int DW    = 26,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  input  logic                     in_valid_i,
  input  logic [CH*DW-1:0]         data_in_i,
  output logic                     out_valid_o,
  output logic [CH*DW-1:0]         data_out_o,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      n_q, n_d;
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [CH*DW-1:0] data_q, data_d;
  logic             mem_we;
  logic             at_end;
  logic [AW:0]      eff_len;
  logic [CH*DW-1:0] mem [DEPTH];

  // A zero or oversized write length means "fill the whole buffer".
  assign eff_len = (len_i == '0 || len_i > DEPTH_N) ? DEPTH_N : len_i;
  assign at_end  = ({1'b0, ptr_q} == n_q - N_ONE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    n_d         = n_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
    data_d      = data_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ptr_d = '0;
          if (mode_i) begin
            state_d = S_WRITE;
            n_d     = eff_len;
          end else begin
            state_d = S_READ;
            n_d     = count_q;
          end
        end
      end

      S_WRITE: begin
        if (in_valid_i) begin
          mem_we      = 1'b1;
          data_d      = data_in_i;
          out_valid_d = 1'b1;
          if (at_end) begin
            last_d  = 1'b1;
            done_d  = 1'b1;
            count_d = n_q;
            ptr_d   = '0;
            state_d = S_IDLE;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end

      S_READ: begin
        // An empty buffer still spends one READ cycle so the done pulse stays registered.
        if (n_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          data_d      = mem[ptr_q];
          out_valid_d = 1'b1;
          if (at_end) begin
            last_d  = 1'b1;
            done_d  = 1'b1;
            ptr_d   = '0;
            state_d = S_IDLE;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      n_q         <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      n_q         <= n_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates replay until a write completes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= data_in_i;
  end

  assign out_valid_o = out_valid_q;
  assign data_out_o  = data_q;
  assign last_o      = last_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);
  assign count_o     = count_q;

endmodule

// File: tb/tb_sample_buffer.sv
// Bench for sample_buffer: directed passes feed a per-cycle expectation table built from the
// pass timing rules; one negedge process compares every output against it each cycle.
module tb_sample_buffer;

  localparam int CH    = 4;
  localparam int DW    = 26;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int W     = CH * DW;
  localparam int TBL   = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          mode_i;
  logic [AW:0]   len_i;
  logic          in_valid_i;
  logic [W-1:0]  data_in_i;
  logic          out_valid_o;
  logic [W-1:0]  data_out_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  logic [AW:0]   count_o;

  sample_buffer #(.CH(CH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .len_i      (len_i),
    .in_valid_i (in_valid_i),
    .data_in_i  (data_in_i),
    .out_valid_o(out_valid_o),
    .data_out_o (data_out_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle index, plus the model's memory and stored count.
  bit         e_valid [TBL];
  bit         e_last  [TBL];
  bit         e_done  [TBL];
  bit         e_busy  [TBL];
  bit         e_rst   [TBL];
  bit [W-1:0] e_data  [TBL];
  int         e_count [TBL];
  bit [W-1:0] mdl_mem [DEPTH];
  bit [W-1:0] wdata   [DEPTH];
  int         mdl_count = 0;
  bit [W-1:0] hold = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < TBL) begin
      if (e_rst[cyc])   hold = '0;
      if (e_valid[cyc]) hold = e_data[cyc];
      check("out_valid", out_valid_o, e_valid[cyc]);
      check("last",      last_o,      e_last[cyc]);
      check("done",      done_o,      e_done[cyc]);
      check("busy",      busy_o,      e_busy[cyc]);
      check("data_out",  data_out_o,  hold);
      check("count",     count_o,     128'(e_count[cyc]));
    end
  end

  function automatic int eff_len(input int l);
    return (l == 0 || l > DEPTH) ? DEPTH : l;
  endfunction

  task automatic put(input int c, input bit [W-1:0] d, input bit lst);
    e_valid[c] = 1'b1;
    e_data[c]  = d;
    e_last[c]  = lst;
    e_done[c]  = lst;
  endtask

  task automatic set_count_from(input int c, input int v);
    for (int j = c; j < TBL; j++) e_count[j] = v;
  endtask

  task automatic clear_from(input int c);
    for (int j = c; j < TBL; j++) begin
      e_valid[j] = 1'b0;
      e_last[j]  = 1'b0;
      e_done[j]  = 1'b0;
      e_busy[j]  = 1'b0;
      e_count[j] = 0;
    end
    e_rst[c] = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++)
      for (int c = 0; c < CH; c++) wdata[i][c*DW +: DW] = DW'(i*4 + c);
  endtask

  task automatic fill_mix();
    for (int i = 0; i < DEPTH; i++)
      for (int c = 0; c < CH; c++) wdata[i][c*DW +: DW] = DW'((i*37 + c*1000) ^ 'h2AAAAAA);
  endtask

  task automatic fill_neg();
    for (int i = 0; i < DEPTH; i++)
      for (int c = 0; c < CH; c++) wdata[i][c*DW +: DW] = DW'(-(i + 1) - 16*c);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that opens the done cycle.
  task automatic write_pass(input int len_v, input bit toggle);
    int n;
    int i;
    int c;
    bit ph;
    n = eff_len(len_v);
    start_i = 1'b1;
    mode_i  = 1'b1;
    len_i   = (AW+1)'(len_v);
    @(posedge clk); #1;
    start_i = 1'b0;
    c  = cyc;
    i  = 0;
    ph = 1'b1;
    while (i < n) begin
      in_valid_i = toggle ? ph : 1'b1;
      e_busy[c]  = 1'b1;
      if (in_valid_i) begin
        data_in_i  = wdata[i];
        mdl_mem[i] = wdata[i];
        put(c + 1, wdata[i], i == n - 1);
        i++;
      end else begin
        data_in_i = '1;
      end
      ph = !ph;
      @(posedge clk); #1;
      c = cyc;
    end
    in_valid_i = 1'b0;
    mdl_count  = n;
    set_count_from(c, n);
  endtask

  task automatic schedule_read(input int t0, input int n);
    if (n == 0) begin
      e_busy[t0 + 1] = 1'b1;
      e_done[t0 + 2] = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        put(t0 + 2 + i, mdl_mem[i], i == n - 1);
        e_busy[t0 + 1 + i] = 1'b1;
      end
    end
  endtask

  // With noise set, a write start is requested on every busy cycle and must be ignored.
  task automatic read_pass(input bit noise);
    int n;
    int t0;
    int m;
    n  = mdl_count;
    t0 = cyc;
    schedule_read(t0, n);
    start_i = 1'b1;
    mode_i  = 1'b0;
    len_i   = 8'd3;
    @(posedge clk); #1;
    start_i = noise;
    mode_i  = 1'b1;
    m = (n == 0) ? 1 : n;
    for (int k = 1; k <= m; k++) begin
      @(posedge clk); #1;
      start_i = (k == m) ? 1'b0 : noise;
    end
    start_i = 1'b0;
  endtask

  task automatic read_abort(input int k);
    int t0;
    t0 = cyc;
    schedule_read(t0, mdl_count);
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (k + 1) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid_o, 1'b0);
    check("abort_data_out",  data_out_o,  '0);
    check("abort_count",     count_o,     '0);
    check("abort_busy",      busy_o,      1'b0);
    check("abort_done",      done_o,      1'b0);
    clear_from(t0 + 3 + k);
    mdl_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    mode_i     = 1'b0;
    len_i      = '0;
    in_valid_i = 1'b0;
    data_in_i  = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_count",     count_o,     '0);
    check("reset_busy",      busy_o,      1'b0);
    check("reset_out_valid", out_valid_o, 1'b0);
    check("reset_data_out",  data_out_o,  '0);

    // Empty buffer: one busy cycle, done the cycle after, no data; starts while busy ignored.
    read_pass(1'b1);
    check("empty_done",      done_o,      1'b1);
    check("empty_out_valid", out_valid_o, 1'b0);
    check("empty_busy",      busy_o,      1'b0);

    // Full-depth write with len=0, then read immediately from the done cycle.
    fill_ramp();
    write_pass(0, 1'b0);
    check("wr128_count", count_o, 8'd128);
    check("wr128_last",  last_o,  1'b1);
    check("wr128_data",  data_out_o, {26'h1FF, 26'h1FE, 26'h1FD, 26'h1FC});
    read_pass(1'b1);
    check("rd128_last", last_o,     1'b1);
    check("rd128_busy", busy_o,     1'b0);
    check("rd128_data", data_out_o, {26'h1FF, 26'h1FE, 26'h1FD, 26'h1FC});
    read_pass(1'b0);
    check("rd128b_done", done_o, 1'b1);

    // Reset in the cycle showing sample 40, then a read that must produce nothing.
    read_abort(40);
    read_pass(1'b0);
    check("post_abort_done",  done_o,  1'b1);
    check("post_abort_count", count_o, '0);

    // Oversized length clamps to DEPTH.
    fill_mix();
    write_pass(200, 1'b0);
    check("wr200_count", count_o, 8'd128);
    read_pass(1'b0);

    // Short write of negative data with a 1,0,1,0 in_valid pattern shrinks the run.
    fill_neg();
    write_pass(5, 1'b1);
    check("wr5_count", count_o, 8'd5);
    check("wr5_ch0",   data_out_o[25:0],   26'h3FFFFFB);
    check("wr5_ch3",   data_out_o[103:78], 26'h3FFFFCB);
    read_pass(1'b0);
    check("rd5_last", last_o,           1'b1);
    check("rd5_ch0",  data_out_o[25:0], 26'h3FFFFFB);

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
